// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage in-order pipeline.
//
// Decides each cycle, with zero latency, which stage registers load, which
// load a bubble, and whether the PC advances. A small IDLE/WAIT FSM follows
// outstanding data-memory accesses. It reports an abandoned access, through
// a one-cycle pulse, and an over-long wait, through a sticky flag.
//
// Ports
//   clk, rst                   core clock, async active-high reset
//   id_rs1_idx/id_rs2_idx      ID source register indices
//   id_rs1_ren/id_rs2_ren      ID source actually read
//   ex_rd_idx, ex_is_load      EX destination / EX holds a load
//   ex_redirect                EX taken branch/jump
//   mem_req, mem_ready         MEM access present / memory response valid
//   wb_trap                    WB commits trap or mret
//   pc_wen, *_wen              PC and stage register write enables
//   *_flush                    stage register loads a bubble at next edge
//   mem_abort                  pulse: outstanding access abandoned by a trap
//   mem_timeout                sticky: a wait exceeded MEM_TIMEOUT cycles
//   stall_cnt                  cycles with pc_wen = 0 (wraps)
module pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_idx,
   input  logic [4:0]  id_rs2_idx,
   input  logic        id_rs1_ren,
   input  logic        id_rs2_ren,
   input  logic [4:0]  ex_rd_idx,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        wb_trap,
   output logic        pc_wen,
   output logic        if_id_wen,
   output logic        id_ex_wen,
   output logic        ex_mem_wen,
   output logic        mem_wb_wen,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        mem_wb_flush,
   output logic        mem_abort,
   output logic        mem_timeout,
   output logic [31:0] stall_cnt
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state, state_nx;
   logic [15:0] wait_cnt;
   logic [15:0] cnt_inc;
   logic        mem_stall;
   logic        load_use;
   logic        timeout_hit;

   // The stall depends only on the inputs, so a response that arrives in the
   // same cycle as the request never costs a cycle.
   assign mem_stall = mem_req & ~mem_ready & ~wb_trap;

   assign load_use = ex_is_load & (ex_rd_idx != 5'd0) &
                     ((id_rs1_ren & (id_rs1_idx == ex_rd_idx)) |
                      (id_rs2_ren & (id_rs2_idx == ex_rd_idx)));

   assign cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

   // The flag is raised on the edge that completes the MEM_TIMEOUT-th wait
   // cycle, but only when the FSM stays in WAIT.
   assign timeout_hit = (state == S_WAIT) && (state_nx == S_WAIT) &&
                        (32'(cnt_inc) == MEM_TIMEOUT);

   always_comb begin
      state_nx     = state;
      pc_wen       = 1'b1;
      if_id_wen    = 1'b1;
      id_ex_wen    = 1'b1;
      ex_mem_wen   = 1'b1;
      mem_wb_wen   = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      unique case (state)
         S_IDLE: if (mem_stall)             state_nx = S_WAIT;
         S_WAIT: if (mem_ready || wb_trap)  state_nx = S_IDLE;
         default:                           state_nx = S_IDLE;
      endcase

      // Priority: trap > memory stall > redirect > load-use > normal.
      // A redirect beats load-use because the dependent ID instruction is
      // squashed anyway.
      if (wb_trap) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mem_stall) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_wen    = 1'b0;
         ex_mem_wen   = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (load_use) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= 16'd0;
         mem_abort   <= 1'b0;
         mem_timeout <= 1'b0;
         stall_cnt   <= 32'd0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && state_nx == S_WAIT)
            wait_cnt <= 16'd0;
         else if (state == S_WAIT)
            wait_cnt <= cnt_inc;
         mem_abort <= (state == S_WAIT) & wb_trap & ~mem_ready;
         if (timeout_hit)
            mem_timeout <= 1'b1;
         if (!pc_wen)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. The driver applies each
// cycle's inputs and queues the expected outputs from a behavioural model.
// The monitor pops one entry and compares it with the DUT at every falling
// edge.
module tb_pipe_ctrl;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs1_idx = '0, id_rs2_idx = '0, ex_rd_idx = '0;
   logic        id_rs1_ren = 0, id_rs2_ren = 0, ex_is_load = 0, ex_redirect = 0;
   logic        mem_req = 0, mem_ready = 0, wb_trap = 0;
   logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic        mem_abort, mem_timeout;
   logic [31:0] stall_cnt;

   pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
      .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
      .ex_rd_idx(ex_rd_idx), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .wb_trap(wb_trap),
      .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
      .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .mem_abort(mem_abort), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2, rd;
      logic       ren1, ren2, ld, redir, req, ready, trap;
   } stim_t;

   typedef struct packed {
      logic [4:0]  wen;    // pc, if_id, id_ex, ex_mem, mem_wb
      logic [3:0]  flush;  // if_id, id_ex, ex_mem, mem_wb
      logic        abort;
      logic        tmo;
      logic [31:0] stalls;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference model: wait bookkeeping in plain counters.
   bit          m_waiting = 0;
   int          m_waited  = 0;
   bit          m_abort   = 0;
   bit          m_tmo     = 0;
   logic [31:0] m_stalls  = 0;

   // Outputs follow the pipeline hazard rules by priority.
   function automatic logic [8:0] model_ctrl(input stim_t s);
      bit mstall, lu;
      mstall = s.req && !s.ready && !s.trap;
      lu = s.ld && s.rd != 0 &&
           ((s.ren1 && s.rs1 == s.rd) || (s.ren2 && s.rs2 == s.rd));
      if (s.trap)       return {5'b11111, 4'b1111};
      else if (mstall)  return {5'b00001, 4'b0001};
      else if (s.redir) return {5'b11111, 4'b1100};
      else if (lu)      return {5'b00111, 4'b0100};
      else              return {5'b11111, 4'b0000};
   endfunction

   task automatic check(input string nm, input int c, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
   endtask

   task automatic step(input stim_t s);
      exp_t       e;
      logic [8:0] ctl;
      bit         nxt_abort;
      @(posedge clk); #1;
      cyc++;
      rst = s.rst; id_rs1_idx = s.rs1; id_rs2_idx = s.rs2; ex_rd_idx = s.rd;
      id_rs1_ren = s.ren1; id_rs2_ren = s.ren2; ex_is_load = s.ld;
      ex_redirect = s.redir; mem_req = s.req; mem_ready = s.ready; wb_trap = s.trap;
      if (s.rst) begin
         m_waiting = 0; m_waited = 0; m_abort = 0; m_tmo = 0; m_stalls = 0;
      end
      ctl = model_ctrl(s);
      e.wen = ctl[8:4]; e.flush = ctl[3:0];
      e.abort = m_abort; e.tmo = m_tmo; e.stalls = m_stalls; e.cyc = cyc;
      q.push_back(e);
      if (!s.rst) begin
         nxt_abort = m_waiting && s.trap && !s.ready;
         if (!ctl[8]) m_stalls = m_stalls + 1;
         if (m_waiting) begin
            if (s.ready || s.trap) m_waiting = 0;
            else begin
               m_waited++;
               if (m_waited == TO) m_tmo = 1;
            end
         end else if (s.req && !s.ready && !s.trap) begin
            m_waiting = 1; m_waited = 0;
         end
         m_abort = nxt_abort;
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("wen", e.cyc, 32'({pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen}),
                  32'(e.wen));
            check("flush", e.cyc, 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}),
                  32'(e.flush));
            check("mem_abort", e.cyc, 32'(mem_abort), 32'(e.abort));
            check("mem_timeout", e.cyc, 32'(mem_timeout), 32'(e.tmo));
            check("stall_cnt", e.cyc, stall_cnt, e.stalls);
         end
      end
   end

   // Driver
   initial begin
      stim_t s;
      s = '0; s.rst = 1;
      step(s); step(s);                          // reset with idle inputs
      s = '0; step(s);
      // load-use on rs1
      s = '0; s.ld = 1; s.rd = 5; s.ren1 = 1; s.rs1 = 5; step(s);
      // x0 destination, then rs2 match with rs2 not read
      s = '0; s.ld = 1; s.rd = 0; s.ren1 = 1; s.rs1 = 0; step(s);
      s = '0; s.ld = 1; s.rd = 7; s.ren2 = 0; s.rs2 = 7; step(s);
      // load-use on rs2
      s = '0; s.ld = 1; s.rd = 9; s.ren2 = 1; s.rs2 = 9; step(s);
      // memory wait: 3 stall cycles, then ready
      s = '0; s.req = 1;
      repeat (3) step(s);
      s.ready = 1; step(s);
      s = '0; step(s);
      // trap in the second WAIT cycle
      s = '0; s.req = 1; step(s); step(s);
      s.trap = 1; step(s);
      s = '0; step(s); step(s);
      // redirect under memory stall, then ready with redirect
      s = '0; s.req = 1; s.redir = 1; step(s); step(s);
      s.ready = 1; step(s);
      s = '0; s.redir = 1; s.ld = 1; s.rd = 3; s.ren1 = 1; s.rs1 = 3; step(s);
      // timeout: ready held low past MEM_TIMEOUT, then ready, flag stays
      s = '0; s.req = 1;
      repeat (6) step(s);
      s.ready = 1; step(s);
      s = '0; repeat (2) step(s);
      // reset asserted mid-WAIT with a trap present: no abort pulse
      s = '0; s.req = 1; step(s); step(s);
      s.trap = 1; s.rst = 1; step(s);
      s = '0; step(s); step(s);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s.rst   = ($urandom_range(199) == 0);
         s.rs1   = 5'($urandom_range(3));
         s.rs2   = 5'($urandom_range(3));
         s.rd    = 5'($urandom_range(3));
         s.ren1  = 1'($urandom_range(1));
         s.ren2  = 1'($urandom_range(1));
         s.ld    = 1'($urandom_range(1));
         s.redir = ($urandom_range(3) == 0);
         s.req   = 1'($urandom_range(1));
         s.ready = ($urandom_range(3) == 0);
         s.trap  = ($urandom_range(15) == 0);
         step(s);
      end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain got=%0d pending expected=0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
